// File: rtl/instr_enc_pkg.sv
// Shared definitions for the instruction encoder/loader: opcode table,
// instruction-class and FSM enums, field widths and opcode decode helpers.
package instr_enc_pkg;

    localparam int OP_W     = 6;
    localparam int REG_W    = 5;
    localparam int FUNCT_W  = 6;
    localparam int IMM_W    = 16;
    localparam int TARGET_W = 26;
    localparam int CLASS_W  = 4;
    localparam int NUM_CLS  = 9;

    localparam logic [OP_W-1:0] OPC_R     = 6'b000000;
    localparam logic [OP_W-1:0] OPC_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OPC_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OPC_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OPC_BLTZ  = 6'b000001;
    localparam logic [OP_W-1:0] OPC_NORI  = 6'b001101;
    localparam logic [OP_W-1:0] OPC_BZ    = 6'b011000;
    localparam logic [OP_W-1:0] OPC_JSPAL = 6'b010011;
    localparam logic [OP_W-1:0] OPC_J     = 6'b000010;

    typedef enum logic [CLASS_W-1:0] {
        CLS_R     = 4'd0,
        CLS_LW    = 4'd1,
        CLS_SW    = 4'd2,
        CLS_BEQ   = 4'd3,
        CLS_BLTZ  = 4'd4,
        CLS_NORI  = 4'd5,
        CLS_BZ    = 4'd6,
        CLS_JSPAL = 4'd7,
        CLS_J     = 4'd8
    } op_class_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FULL,
        ST_ERR
    } state_e;

    // Opcode field back to a one-hot class; all-zero for unknown opcodes.
    function automatic logic [NUM_CLS-1:0] opcode_to_onehot(input logic [OP_W-1:0] opc);
        logic [NUM_CLS-1:0] oh;
        oh = '0;
        case (opc)
            OPC_R:     oh[CLS_R]     = 1'b1;
            OPC_LW:    oh[CLS_LW]    = 1'b1;
            OPC_SW:    oh[CLS_SW]    = 1'b1;
            OPC_BEQ:   oh[CLS_BEQ]   = 1'b1;
            OPC_BLTZ:  oh[CLS_BLTZ]  = 1'b1;
            OPC_NORI:  oh[CLS_NORI]  = 1'b1;
            OPC_BZ:    oh[CLS_BZ]    = 1'b1;
            OPC_JSPAL: oh[CLS_JSPAL] = 1'b1;
            OPC_J:     oh[CLS_J]     = 1'b1;
            default:   oh            = '0;
        endcase
        return oh;
    endfunction

    // Class code to one-hot; all-zero for illegal codes.
    function automatic logic [NUM_CLS-1:0] class_to_onehot(input logic [CLASS_W-1:0] cls);
        logic [NUM_CLS-1:0] oh;
        oh = '0;
        if (int'(cls) < NUM_CLS) begin
            oh[cls] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Request channel of the instruction encoder/loader: valid/ready handshake
// plus the instruction class and raw operand fields.
interface instr_encoder_loader_if;
    import instr_enc_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [CLASS_W-1:0]  op_class;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    shamt;
    logic [FUNCT_W-1:0]  funct;
    logic [IMM_W-1:0]    imm;
    logic [TARGET_W-1:0] target;

    modport master (
        output in_valid, op_class, rs, rt, rd, shamt, funct, imm, target,
        input  in_ready
    );

    modport slave (
        input  in_valid, op_class, rs, rt, rd, shamt, funct, imm, target,
        output in_ready
    );

endinterface

// File: rtl/instr_field_pack.sv
// Combinational packer: instruction class plus operand fields to a 32-bit
// MIPS-lite word. Illegal class codes raise illegal and produce zero.
module instr_field_pack
    import instr_enc_pkg::*;
(
    input  logic [CLASS_W-1:0]  op_class,
    input  logic [REG_W-1:0]    rs,
    input  logic [REG_W-1:0]    rt,
    input  logic [REG_W-1:0]    rd,
    input  logic [REG_W-1:0]    shamt,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic [IMM_W-1:0]    imm,
    input  logic [TARGET_W-1:0] target,
    output logic [31:0]         word,
    output logic                illegal
);

    // Select opcode and field layout by class.
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (op_class)
            CLS_R:     word = {OPC_R, rs, rt, rd, shamt, funct};
            CLS_LW:    word = {OPC_LW, rs, rt, imm};
            CLS_SW:    word = {OPC_SW, rs, rt, imm};
            CLS_BEQ:   word = {OPC_BEQ, rs, rt, imm};
            CLS_BLTZ:  word = {OPC_BLTZ, rs, 5'b00000, imm};
            CLS_NORI:  word = {OPC_NORI, rs, rt, imm};
            CLS_BZ:    word = {OPC_BZ, rs, rt, imm};
            CLS_JSPAL: word = {OPC_JSPAL, target};
            CLS_J:     word = {OPC_J, target};
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: accepts encode requests during a load session
// and writes packed words sequentially into instruction memory.
// Optional macro ENC_SELFCHECK_EN: decodes each written opcode back to a
// class and flags (sticky) any disagreement on selfcheck_err.
module instr_encoder_loader
    import instr_enc_pkg::*;
#(
    parameter int                DEPTH     = 256,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        finish,
    instr_encoder_loader_if.slave       req,
    output logic                        imem_we,
    output logic [ADDR_W-1:0]           imem_addr,
    output logic [31:0]                 imem_wdata,
    output logic [$clog2(DEPTH+1)-1:0]  word_count,
    output logic                        full,
    output logic                        err,
    output logic                        selfcheck_err
);

    localparam int               CNT_W     = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DEPTH - 1);

    state_e              state, state_nxt;
    logic [31:0]         packed_word;
    logic                pack_illegal;
    logic                accept, legal_acc, illegal_acc, last_word, start_ok;
    logic [ADDR_W-1:0]   next_addr;

    instr_field_pack u_pack (
        .op_class (req.op_class),
        .rs       (req.rs),
        .rt       (req.rt),
        .rd       (req.rd),
        .shamt    (req.shamt),
        .funct    (req.funct),
        .imm      (req.imm),
        .target   (req.target),
        .word     (packed_word),
        .illegal  (pack_illegal)
    );

    assign req.in_ready = (state == ST_LOAD);
    assign accept       = req.in_valid & req.in_ready;
    assign legal_acc    = accept & ~pack_illegal;
    assign illegal_acc  = accept & pack_illegal;
    assign last_word    = (word_count == LAST_CNT);
    // start opens a session only outside LOAD, and finish takes priority.
    assign start_ok     = start & ~finish & (state != ST_LOAD);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_ok) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (finish)                      state_nxt = ST_IDLE;
                else if (illegal_acc)            state_nxt = ST_ERR;
                else if (legal_acc && last_word) state_nxt = ST_FULL;
            end
            ST_FULL, ST_ERR: begin
                if (finish)        state_nxt = ST_IDLE;
                else if (start_ok) state_nxt = ST_LOAD;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Write port, address/word counters and session status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
            next_addr  <= BASE_ADDR;
            word_count <= '0;
            full       <= 1'b0;
            err        <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (start_ok) begin
                imem_addr  <= BASE_ADDR;
                next_addr  <= BASE_ADDR;
                word_count <= '0;
                full       <= 1'b0;
                err        <= 1'b0;
            end else if (legal_acc) begin
                imem_we    <= 1'b1;
                imem_wdata <= packed_word;
                imem_addr  <= next_addr;
                next_addr  <= next_addr + ADDR_W'(4);
                word_count <= word_count + CNT_W'(1);
                if (last_word) full <= 1'b1;
            end else if (illegal_acc) begin
                err <= 1'b1;
            end
        end
    end

`ifdef ENC_SELFCHECK_EN
    logic [CLASS_W-1:0] cls_q;
    logic               sc_mismatch;

    assign sc_mismatch = (opcode_to_onehot(imem_wdata[31:26]) != class_to_onehot(cls_q));

    // Remember the class of the word being written and flag decode mismatches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cls_q         <= '0;
            selfcheck_err <= 1'b0;
        end else begin
            if (legal_acc) cls_q <= req.op_class;
            if (start_ok) begin
                selfcheck_err <= 1'b0;
            end else if (imem_we && sc_mismatch) begin
                selfcheck_err <= 1'b1;
            end
        end
    end
`else
    assign selfcheck_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader (DEPTH=4): encodings of every
// class, back-to-back throughput, full, illegal class, reset and finish.
module tb_instr_encoder_loader;
    import instr_enc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        finish;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [2:0]  word_count;
    logic        full;
    logic        err;
    logic        selfcheck_err;

    int checks = 0;
    int errors = 0;

    instr_encoder_loader_if req_if ();

    instr_encoder_loader #(
        .DEPTH     (4),
        .ADDR_W    (32),
        .BASE_ADDR (32'h0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .finish        (finish),
        .req           (req_if.slave),
        .imem_we       (imem_we),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .word_count    (word_count),
        .full          (full),
        .err           (err),
        .selfcheck_err (selfcheck_err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [3:0] cls, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                           input logic [15:0] imm, input logic [25:0] tgt);
        req_if.in_valid = 1'b1;
        req_if.op_class = cls;
        req_if.rs       = rs;
        req_if.rt       = rt;
        req_if.rd       = rd;
        req_if.shamt    = sh;
        req_if.funct    = fn;
        req_if.imm      = imm;
        req_if.target   = tgt;
    endtask

    task automatic chk_wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [2:0] cnt);
        chk({tag, "_we"},   64'(imem_we), 64'd1);
        chk({tag, "_addr"}, 64'(imem_addr), 64'(addr));
        chk({tag, "_data"}, 64'(imem_wdata), 64'(data));
        chk({tag, "_cnt"},  64'(word_count), 64'(cnt));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_we"},    64'(imem_we), 64'd0);
        chk({tag, "_addr"},  64'(imem_addr), 64'd0);
        chk({tag, "_data"},  64'(imem_wdata), 64'd0);
        chk({tag, "_cnt"},   64'(word_count), 64'd0);
        chk({tag, "_full"},  64'(full), 64'd0);
        chk({tag, "_err"},   64'(err), 64'd0);
        chk({tag, "_sc"},    64'(selfcheck_err), 64'd0);
        chk({tag, "_ready"}, 64'(req_if.in_ready), 64'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        finish = 1'b0;
        set_req(4'd0, '0, '0, '0, '0, '0, '0, '0);
        req_if.in_valid = 1'b0;
        cyc();
        cyc();
        chk_reset("rst");
        rst_n = 1'b1;

        // R format
        start = 1'b1; cyc(); start = 1'b0;
        chk("open_ready", 64'(req_if.in_ready), 64'd1);
        set_req(CLS_R, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, '0, '0);
        cyc(); req_if.in_valid = 1'b0;
        chk_wr("r", 32'h0, 32'h00221820, 3'd1);
        cyc();
        chk("r_we_low", 64'(imem_we), 64'd0);
        chk("r_hold", 64'(imem_wdata), 64'h00221820);
        finish = 1'b1; cyc(); finish = 1'b0;
        chk("fin_ready", 64'(req_if.in_ready), 64'd0);
        chk("fin_cnt", 64'(word_count), 64'd1);

        // Back-to-back I and J formats, filling DEPTH=4
        start = 1'b1; cyc(); start = 1'b0;
        chk("s2_cnt", 64'(word_count), 64'd0);
        set_req(CLS_LW, 5'd2, 5'd3, '0, '0, '0, 16'h0010, '0);
        cyc();
        chk_wr("lw", 32'h0, 32'h8C430010, 3'd1);
        set_req(CLS_NORI, 5'd4, 5'd5, '0, '0, '0, 16'hFFFF, '0);
        cyc();
        chk_wr("nori", 32'h4, 32'h3485FFFF, 3'd2);
        set_req(CLS_J, '0, '0, '0, '0, '0, '0, 26'h40);
        cyc();
        chk_wr("j", 32'h8, 32'h08000040, 3'd3);
        set_req(CLS_JSPAL, '0, '0, '0, '0, '0, '0, 26'h0);
        cyc();
        chk_wr("jspal", 32'hC, 32'h4C000000, 3'd4);
        chk("full_set", 64'(full), 64'd1);
        chk("full_ready", 64'(req_if.in_ready), 64'd0);
        set_req(CLS_BLTZ, 5'd1, 5'd7, '0, '0, '0, 16'h0008, '0);
        cyc(); req_if.in_valid = 1'b0;
        chk("fifth_we", 64'(imem_we), 64'd0);
        chk("fifth_cnt", 64'(word_count), 64'd4);
        finish = 1'b1; cyc(); finish = 1'b0;
        chk("full_fin_ready", 64'(req_if.in_ready), 64'd0);
        chk("full_fin_full", 64'(full), 64'd1);
        chk("full_fin_cnt", 64'(word_count), 64'd4);

        // Remaining I formats, BLTZ with rt forced to zero
        start = 1'b1; cyc(); start = 1'b0;
        chk("s3_full", 64'(full), 64'd0);
        chk("s3_ready", 64'(req_if.in_ready), 64'd1);
        set_req(CLS_BLTZ, 5'd1, 5'd7, '0, '0, '0, 16'h0008, '0);
        cyc();
        chk_wr("bltz", 32'h0, 32'h04200008, 3'd1);
        set_req(CLS_SW, 5'd3, 5'd4, '0, '0, '0, 16'h0004, '0);
        cyc();
        chk_wr("sw", 32'h4, 32'hAC640004, 3'd2);
        set_req(CLS_BEQ, 5'd1, 5'd2, '0, '0, '0, 16'hFFFE, '0);
        cyc();
        chk_wr("beq", 32'h8, 32'h1022FFFE, 3'd3);
        set_req(CLS_BZ, 5'd5, 5'd0, '0, '0, '0, 16'h0003, '0);
        cyc(); req_if.in_valid = 1'b0;
        chk_wr("bz", 32'hC, 32'h60A00003, 3'd4);
        finish = 1'b1; cyc(); finish = 1'b0;

        // Illegal class
        start = 1'b1; cyc(); start = 1'b0;
        set_req(4'd12, '0, '0, '0, '0, '0, '0, '0);
        cyc(); req_if.in_valid = 1'b0;
        chk("ill_we", 64'(imem_we), 64'd0);
        chk("ill_err", 64'(err), 64'd1);
        chk("ill_ready", 64'(req_if.in_ready), 64'd0);
        chk("ill_cnt", 64'(word_count), 64'd0);
        cyc();
        chk("ill_sticky", 64'(err), 64'd1);
        start = 1'b1; cyc(); start = 1'b0;
        chk("ill_clr_err", 64'(err), 64'd0);
        chk("ill_clr_cnt", 64'(word_count), 64'd0);
        chk("ill_clr_ready", 64'(req_if.in_ready), 64'd1);

        // Reset right after an accepted request
        set_req(CLS_R, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, '0, '0);
        cyc(); req_if.in_valid = 1'b0;
        chk("prerst_we", 64'(imem_we), 64'd1);
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        chk_reset("midrst");

        // Acceptance in the same cycle as finish
        start = 1'b1; cyc(); start = 1'b0;
        set_req(CLS_R, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, '0, '0);
        finish = 1'b1;
        cyc(); req_if.in_valid = 1'b0; finish = 1'b0;
        chk_wr("fin_acc", 32'h0, 32'h00221820, 3'd1);
        chk("fin_acc_ready", 64'(req_if.in_ready), 64'd0);
        cyc();
        chk("fin_acc_we_low", 64'(imem_we), 64'd0);

        // Simultaneous start and finish: finish wins, stays idle
        start = 1'b1; finish = 1'b1; cyc(); start = 1'b0; finish = 1'b0;
        chk("sf_ready", 64'(req_if.in_ready), 64'd0);
        chk("sf_cnt", 64'(word_count), 64'd1);
        chk("sc_clean", 64'(selfcheck_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the MIPS-lite opcode decoder: takes an instruction class plus operand fields over a valid/ready handshake and packs them into 32-bit instruction words.
- Writes each packed word sequentially into instruction memory through a single-cycle write port.
- Used by the bench and by boot logic to load programs (R, lw, sw, beq, bltz, nori, bz, jspal, j) without a hand-assembled hex file.

Parameters:
- DEPTH, 256, max words per load session (≥1).
- ADDR_W, 32, width of imem_addr (byte address).
- BASE_ADDR, 0, byte address of the first word in each session; word-aligned.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  pulse; opens a load session (honoured in IDLE, ERR and FULL)
- finish  in  1  pulse; closes the session and returns to IDLE
- in_valid  in  1  request valid
- in_ready  out  1  block accepts the request this cycle
- op_class  in  4  0=R 1=LW 2=SW 3=BEQ 4=BLTZ 5=NORI 6=BZ 7=JSPAL 8=J; 9-15 illegal
- rs, rt, rd, shamt  in  5 each  register and shift fields
- funct  in  6  R-format function
- imm  in  16  I-format immediate
- target  in  26  J-format target
- imem_we  out  1  write strobe
- imem_addr  out  ADDR_W  byte address
- imem_wdata  out  32  encoded word
- word_count  out  $clog2(DEPTH+1)  words written this session
- full  out  1  DEPTH words written
- err  out  1  sticky illegal-class flag
- selfcheck_err  out  1  see Optional Feature

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE. imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, word_count=0, full=0, err=0, selfcheck_err=0. Reset overrides any session in progress; a pending write is dropped.
- Opcodes:
  - R=000000, LW=100011, SW=101011, BEQ=000100, BLTZ=000001
  - NORI=001101, BZ=011000, JSPAL=010011, J=000010
- Word formats:
  - R: {000000, rs, rt, rd, shamt, funct}
  - LW, SW, BEQ, NORI, BZ: {op, rs, rt, imm}
  - BLTZ: {op, rs, 00000, imm}; the rt input is ignored.
  - JSPAL, J: {op, target}
- FSM states: IDLE, LOAD, FULL, ERR.
  - IDLE: start → LOAD; word_count clears to 0, address resets to BASE_ADDR, full and err clear.
  - LOAD: in_ready=1. A request is accepted when in_valid & in_ready.
  - LOAD, legal class: the encoded word is registered. imem_we=1 for exactly one cycle in the cycle after acceptance, with the current address. Address then advances by 4 and word_count increments.
  - LOAD, illegal class: the request is consumed with no write, err is set, and the FSM goes to ERR.
  - LOAD → FULL: when the accepted word makes word_count reach DEPTH.
  - FULL: in_ready=0 and full=1. The last write still completes.
  - ERR: in_ready=0. err holds until start or reset.
  - finish in LOAD, FULL or ERR → IDLE; word_count and full hold their values. finish in IDLE has no effect.
- in_ready is 0 in IDLE, FULL and ERR.
- Simultaneous start and finish: finish wins.
- An acceptance in the same cycle as finish is honoured: the write issues next cycle, then the FSM is in IDLE.
- Throughput is 1 word per cycle; write latency is 1 cycle after acceptance.
- imem_wdata holds its last value when imem_we=0.
- The address counter is ADDR_W wide and wraps modulo 2^ADDR_W. No wrap occurs within DEPTH words unless BASE_ADDR is near the top of the address space.

Optional Feature:
- Macro ENC_SELFCHECK_EN.
- Defined: on each write, imem_wdata[31:26] is decoded back into a one-hot class using the opcode table above. If it differs from the registered op_class, selfcheck_err is set; it is sticky until start or reset. The check compares within the same cycle as imem_we and adds no latency.
- Undefined: selfcheck_err is tied to 0 and no decode logic is built.

Decomposition:
- Package instr_enc_pkg: 6-bit opcode constants, op_class enum (4 bits), FSM state enum, field-width localparams.
- Sub-module instr_field_pack: combinational; op_class plus fields in, 32-bit word and illegal flag out.
- The FSM, counter and output registers live in the top block.

Test Plan:
- R format: start, then R class with rs=1, rt=2, rd=3, shamt=0, funct=0x20 → next cycle imem_we=1, addr=0x0, wdata=0x00221820, word_count=1.
- I format: LW with rs=2, rt=3, imm=0x0010, then NORI with rs=4, rt=5, imm=0xFFFF, back-to-back → wdata 0x8C430010 at 0x0, then 0x3485FFFF at 0x4.
- J format and BLTZ: J with target=0x40 → 0x08000040; JSPAL with target=0 → 0x4C000000; BLTZ with rs=1, rt=7, imm=8 → 0x04200008 (rt forced to 0).
- Full condition: DEPTH=4, five valid requests → four writes at 0x0, 0x4, 0x8, 0xC; full=1; in_ready=0 before the fifth request; finish → IDLE.
- Illegal class: op_class=12 during LOAD → no write, err=1, in_ready=0; start → err=0, word_count=0, in_ready=1.
- Reset: rst_n low in the cycle after an accepted request → imem_we=0 in the following cycle, all outputs at reset values. With ENC_SELFCHECK_EN defined and a clean program, selfcheck_err stays 0.
